// File: rtl/reg_write_sched.sv
// ---------------------------------------------------------------------------
// reg_write_sched
//
// Write-port scheduler that sits directly in front of the 3-bit register
// bank. Write requests (address + 3-bit data) arrive over a valid/ready
// handshake and are buffered in a small FIFO. At most one write per cycle is
// issued as a registered one-hot select, write strobe and write data, which
// fan out to every register in the bank. Stall holds issue, flush discards
// everything buffered, and a sticky flag records out-of-range requests.
//
// Parameters
//   NREG    number of registers in the bank (width of o_chosen)
//   ADDR_W  request address width, 2**ADDR_W >= NREG
//   DEPTH   FIFO entries, 1..8
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous reset, active low
//   i_req_valid  write request present
//   o_req_ready  scheduler can accept a request
//   i_req_addr   target register index
//   i_req_data   value to write
//   i_stall      bank not writable this cycle, hold issue
//   i_flush      discard all buffered requests
//   i_err_clr    clear the sticky error flag
//   o_chosen     one-hot register select (registered)
//   o_w_en       write strobe (registered)
//   o_w_data     write data (registered)
//   o_busy       FIFO non-empty or write strobe high
//   o_err        sticky out-of-range request flag
// ---------------------------------------------------------------------------
module reg_write_sched #(
    parameter int NREG   = 4,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [2:0]        i_req_data,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_err_clr,
    output logic [NREG-1:0]   o_chosen,
    output logic              o_w_en,
    output logic [2:0]        o_w_data,
    output logic              o_busy,
    output logic              o_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   NREG_C   = (ADDR_W + 1)'(NREG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STALLED
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;

    logic [ADDR_W-1:0] r_addrMem [DEPTH];
    logic [2:0]        r_dataMem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_countNext;

    logic [NREG-1:0]   r_chosen;
    logic [NREG-1:0]   w_chosenNext;
    logic [2:0]        r_wData;
    logic [2:0]        w_dataNext;
    logic              r_err;

    logic              w_accept;
    logic              w_inRange;
    logic              w_push;
    logic              w_pop;
    logic              w_notEmpty;

    // Ready never looks at a same-cycle pop: a full FIFO stays closed for
    // one cycle even while it drains.
    assign o_req_ready = i_rst_n & (r_count < DEPTH_C);

    assign w_accept   = i_req_valid & o_req_ready;
    assign w_inRange  = ({1'b0, i_req_addr} < NREG_C);
    assign w_notEmpty = (r_count != '0);

    // Flush wins over everything, including a push that lands on the same
    // edge; stall only blocks the pop side.
    assign w_push = w_accept & w_inRange & ~i_flush;
    assign w_pop  = w_notEmpty & ~i_stall & ~i_flush;

    always_comb begin
        w_countNext = r_count;
        if (i_flush) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // FIFO storage carries no reset: an entry is only read after it was
    // written, and count/pointers are what define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addrMem[r_wrPtr] <= i_req_addr;
            r_dataMem[r_wrPtr] <= i_req_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
            if (i_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
                end
            end
        end
    end

    // Issue decision. The select/strobe/data are computed here and
    // registered, so o_chosen is all-zero in every state except ISSUE.
    // w_data keeps its last issued value when nothing is issued.
    always_comb begin
        w_stateNext  = S_IDLE;
        w_chosenNext = '0;
        w_dataNext   = r_wData;
        if (i_flush) begin
            w_stateNext = S_IDLE;
        end else if (i_stall) begin
            w_stateNext = (w_countNext != '0) ? S_STALLED : S_IDLE;
        end else if (w_notEmpty) begin
            w_stateNext  = S_ISSUE;
            w_chosenNext = NREG'(1) << r_addrMem[r_rdPtr];
            w_dataNext   = r_dataMem[r_rdPtr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_chosen <= '0;
            r_wData  <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_chosen <= w_chosenNext;
            r_wData  <= w_dataNext;
        end
    end

    // A dropped out-of-range request sets the flag even when a clear
    // arrives on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_inRange) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_w_en    = (r_state == S_ISSUE);
    assign o_chosen  = r_chosen;
    assign o_w_data  = r_wData;
    assign o_err     = r_err;
    assign o_busy    = w_notEmpty | o_w_en;

endmodule

// File: tb/tb_reg_write_sched.sv
// ---------------------------------------------------------------------------
// tb_reg_write_sched
//
// Two schedulers share one stimulus stream: dutA (NREG=4) covers the issue
// path, dutB (NREG=3) makes address 3 out of range for the error flag.
// Expected writes are queued when a request is accepted and popped when the
// DUT strobes w_en.
// ---------------------------------------------------------------------------
module tb_reg_write_sched;

    localparam int DEPTH = 2;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b1;
    logic       reqValid = 1'b0;
    logic [1:0] reqAddr  = '0;
    logic [2:0] reqData  = '0;
    logic       stall    = 1'b0;
    logic       flush    = 1'b0;
    logic       errClr   = 1'b0;

    logic       readyA, wEnA, busyA, errA;
    logic [3:0] chosenA;
    logic [2:0] wDataA;
    logic       readyB, wEnB, busyB, errB;
    logic [2:0] chosenB;
    logic [2:0] wDataB;

    int         checks    = 0;
    int         errors    = 0;
    int         cntA      = 0;
    int         cntB      = 0;
    logic       errBModel = 1'b0;
    logic [2:0] lastData  = '0;
    logic [4:0] sbQueue[$];

    always #5 clk = ~clk;

    reg_write_sched #(.NREG(4), .ADDR_W(2), .DEPTH(DEPTH)) dutA (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .o_req_ready (readyA),
        .i_req_addr  (reqAddr),
        .i_req_data  (reqData),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_err_clr   (errClr),
        .o_chosen    (chosenA),
        .o_w_en      (wEnA),
        .o_w_data    (wDataA),
        .o_busy      (busyA),
        .o_err       (errA)
    );

    reg_write_sched #(.NREG(3), .ADDR_W(2), .DEPTH(DEPTH)) dutB (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .o_req_ready (readyB),
        .i_req_addr  (reqAddr),
        .i_req_data  (reqData),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_err_clr   (errClr),
        .o_chosen    (chosenB),
        .o_w_en      (wEnB),
        .o_w_data    (wDataB),
        .o_busy      (busyB),
        .o_err       (errB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, advances one rising edge, updates the
    // model and checks every output of dutA plus ready/err of dutB.
    task automatic applyStimulus(input logic vIn, input logic [1:0] aIn,
                                 input logic [2:0] dIn, input logic stallIn,
                                 input logic flushIn, input logic clrIn);
        logic       expReadyA, expReadyB, popA, popB, pushA, pushB, badB;
        logic [4:0] entry;
        logic [3:0] oneHot;
        reqValid = vIn;
        reqAddr  = aIn;
        reqData  = dIn;
        stall    = stallIn;
        flush    = flushIn;
        errClr   = clrIn;
        expReadyA = (cntA < DEPTH);
        expReadyB = (cntB < DEPTH);
        checkOutput("ready_a", readyA, expReadyA);
        checkOutput("ready_b", readyB, expReadyB);
        popA  = !flushIn && !stallIn && (cntA != 0);
        popB  = !flushIn && !stallIn && (cntB != 0);
        pushA = vIn && expReadyA && !flushIn;
        pushB = vIn && expReadyB && (aIn < 2'd3) && !flushIn;
        badB  = vIn && expReadyB && (aIn == 2'd3);
        @(posedge clk);
        if (flushIn) begin
            sbQueue.delete();
        end else if (pushA) begin
            sbQueue.push_back({aIn, dIn});
        end
        cntA = flushIn ? 0 : cntA + int'(pushA) - int'(popA);
        cntB = flushIn ? 0 : cntB + int'(pushB) - int'(popB);
        errBModel = badB ? 1'b1 : (clrIn ? 1'b0 : errBModel);
        #1;
        checkOutput("w_en", wEnA, popA);
        if (wEnA === 1'b1) begin
            checkOutput("sb_pending", (sbQueue.size() > 0), 1'b1);
            if (sbQueue.size() > 0) begin
                entry  = sbQueue.pop_front();
                oneHot = 4'b0001 << entry[4:3];
                checkOutput("chosen", chosenA, oneHot);
                checkOutput("w_data", wDataA, entry[2:0]);
                lastData = entry[2:0];
            end
        end else begin
            checkOutput("chosen_idle", chosenA, 4'b0000);
            checkOutput("w_data_hold", wDataA, lastData);
        end
        checkOutput("busy", busyA, (cntA != 0) || popA);
        checkOutput("err_a", errA, 1'b0);
        checkOutput("err_b", errB, errBModel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drops reset away from a clock edge, checks the immediate clear and
    // releases it on the next falling edge.
    task automatic assertReset();
        rstN = 1'b0;
        #1;
        checkOutput("rst_w_en", wEnA, 1'b0);
        checkOutput("rst_chosen", chosenA, 4'b0000);
        checkOutput("rst_w_data", wDataA, 3'b000);
        checkOutput("rst_err_a", errA, 1'b0);
        checkOutput("rst_err_b", errB, 1'b0);
        checkOutput("rst_ready", readyA, 1'b0);
        checkOutput("rst_busy", busyA, 1'b0);
        sbQueue.delete();
        cntA = 0;
        cntB = 0;
        errBModel = 1'b0;
        lastData = '0;
        reqValid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        errClr = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_release_ready", readyA, 1'b1);
    endtask

    initial begin
        #1;
        assertReset();

        // single request, issued two edges after acceptance for one cycle
        applyStimulus(1'b1, 2'd2, 3'b101, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_no_early_w_en", wEnA, 1'b0);
        idle(1);
        checkOutput("t1_chosen", chosenA, 4'b0100);
        checkOutput("t1_w_data", wDataA, 3'b101);
        idle(1);
        checkOutput("t1_single_pulse", wEnA, 1'b0);

        // back-to-back stream drains as it fills
        applyStimulus(1'b1, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0);
        idle(2);

        // fill under stall; a full FIFO rejects even while it pops
        applyStimulus(1'b1, 2'd0, 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 3'b100, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_full_ready", readyA, 1'b0);
        applyStimulus(1'b1, 2'd2, 3'b110, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 3'b001, 1'b0, 1'b0, 1'b0);
        idle(2);

        // out-of-range on dutB: dropped, sticky, set beats clear
        applyStimulus(1'b1, 2'd3, 3'b010, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_err_set", errB, 1'b1);
        idle(2);
        applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_err_clr", errB, 1'b0);
        applyStimulus(1'b1, 2'd3, 3'b101, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_set_wins", errB, 1'b1);
        idle(1);
        applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // flush two stalled entries alongside a new request
        applyStimulus(1'b1, 2'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 3'b111, 1'b1, 1'b1, 1'b0);
        idle(1);
        checkOutput("t5_busy_clear", busyA, 1'b0);
        // one entry, flush with an acceptable request: push discarded
        applyStimulus(1'b1, 2'd3, 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 3'b110, 1'b0, 1'b1, 1'b0);
        idle(3);

        // reset while a write is on the bus with more queued behind it
        applyStimulus(1'b1, 2'd1, 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_rst_w_en", wEnA, 1'b1);
        assertReset();
        idle(4);
        checkOutput("t6_queue_empty", sbQueue.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/reg_write_sched.md
# reg_write_sched

Write-port scheduler placed directly upstream of the 3-bit register bank. It accepts register write requests (address + 3-bit data) over a valid/ready handshake and buffers them in a small FIFO. It issues at most one write per cycle as a registered one-hot `chosen` vector, `w_en` and `w_data`, which drive the `chosen`/`w_en`/`w_data` inputs of every register in the bank. It also supports stall, flush and a sticky out-of-range error.

## Interface
- `NREG`, 4: number of registers in the bank; width of `chosen`.
- `ADDR_W`, 2: request address width; must satisfy 2^ADDR_W >= NREG.
- `DEPTH`, 2: FIFO entries; legal range 1..8.

- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  scheduler can accept a request.
- `req_addr`  in  ADDR_W  target register index.
- `req_data`  in  3  value to write.
- `stall`  in  1  bank not writable this cycle; hold issue.
- `flush`  in  1  discard all buffered requests.
- `err_clr`  in  1  clear sticky error.
- `chosen`  out  NREG  one-hot register select, registered.
- `w_en`  out  1  write strobe, registered.
- `w_data`  out  3  write data, registered.
- `busy`  out  1  FIFO non-empty or `w_en` high.
- `err`  out  1  sticky out-of-range request flag.

## Operation
- Reset (`rst` low, asynchronous):
  - FIFO count 0; `chosen`=0, `w_en`=0, `w_data`=0, `err`=0.
  - `req_ready`=0 while `rst` is low.
- Accept: a handshake occurs when `req_valid & req_ready` at a rising edge.
  - `req_ready` = `rst & (count < DEPTH)`.
  - No full-FIFO bypass: a pop in the same cycle does not raise `req_ready`.
- In-range request (`req_addr < NREG`): pushed to the FIFO tail.
- Out-of-range request (`req_addr >= NREG`):
  - The handshake completes and the request is dropped; the FIFO is unchanged.
  - `err` is set at that edge.
- `err`:
  - Cleared by `err_clr` at the next edge.
  - If a new out-of-range accept coincides with `err_clr`, set wins.
- Issue state machine:
  - IDLE: FIFO empty, `w_en`=0.
  - ISSUE: head popped, `w_en`=1.
  - STALLED: FIFO non-empty and `stall`=1.
- Transitions, each rising edge, in priority order:
  - `flush`: FIFO count 0, same-cycle push discarded, `w_en`/`chosen` 0 → IDLE.
  - `stall`: no pop; `w_en`=0, `chosen`=0 → STALLED if non-empty, else IDLE.
  - FIFO non-empty: pop head; `chosen` = one-hot(head addr), `w_data` = head data, `w_en`=1 → ISSUE.
  - Otherwise: `w_en`=0, `chosen`=0, `w_data` holds its last value → IDLE.
- A push and a pop in the same cycle are both performed; count is unchanged.
- Writes issue strictly in acceptance order; no coalescing of same-address requests.
- `chosen` is all-zero whenever `w_en`=0 and exactly one-hot whenever `w_en`=1.

## Timing
- Acceptance to strobe: a request accepted at edge k into an empty FIFO, with no stall, asserts `w_en` after edge k+1. The bank register captures it at edge k+2.
- Sustained throughput: one write per cycle while `req_valid` stays high and `stall` stays low.
- Stall raised in a cycle: `w_en` is 0 after the next edge. Issue resumes one edge after `stall` falls.
- Flush at edge k: `w_en`=0 after edge k. `req_ready`=1 in cycle k+1 (if `rst` high).
- Reset asserted mid-operation: all outputs and the FIFO clear immediately. The pending write is lost and `w_en` never glitches high.
- `busy` is combinational from count and registered `w_en`.

## Test plan
- Reset release, then one request addr=2 data=3'b101 → `w_en`=1, `chosen`=4'b0100, `w_data`=3'b101 for exactly one cycle, two edges after acceptance.
- Three back-to-back requests (0,3'b001), (1,3'b010), (3,3'b111) with DEPTH=2 → issued in order on consecutive cycles; `req_ready` never drops because the FIFO drains as it fills.
- Hold `stall`=1 and push two requests → `req_ready` falls to 0 after the second; `w_en` stays 0. Release `stall` → both issue on consecutive cycles.
- Request addr=3 with NREG=3 → handshake completes, no write, `err`=1. Pulse `err_clr` → `err`=0. Then `err_clr` together with another bad request → `err` stays 1.
- Two entries buffered under stall, assert `flush` alongside a new valid request → FIFO empty, no `w_en` pulse, `busy`=0 one cycle later.
- Drop `rst` while `w_en`=1 → `w_en`, `chosen`, `w_data`, `err` are 0 immediately. After release, `req_ready`=1 and the earlier queued requests never issue.
